// File: rtl/led_fade_scheduler.sv
// Staggered fade-in / hold / fade-out sequencer for CH LED PWM channels sharing one PWM counter.
// Optional quadratic brightness curve when LED_FADE_GAMMA_EN is defined (adds one output pipeline stage).
module led_fade_scheduler #(
  parameter int CH         = 8,
  parameter int PWM_BITS   = 6,
  parameter int STEP_DIV   = 2,
  parameter int HOLD_STEPS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop,
  input  logic                  wave,
  output logic [CH-1:0]         pwm_out,
  output logic                  busy,
  output logic                  cycle_done,
  output logic [$clog2(CH)-1:0] active_ch
);
  localparam int AW = $clog2(CH);
  localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int HW = $clog2(HOLD_STEPS + 1);
  localparam logic [PWM_BITS-1:0] DMAX      = '1;
  localparam logic [PWM_BITS-1:0] HALF      = PWM_BITS'(1) << (PWM_BITS - 1);
  localparam logic [DW-1:0]       DIV_LAST  = DW'(STEP_DIV - 1);
  localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_STEPS - 1);
  localparam logic [AW-1:0]       TOP_CH    = AW'(CH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} g_state_t;
  typedef enum logic [1:0] {C_OFF, C_UP, C_HOLD, C_DOWN} ch_state_t;

  g_state_t            state_reg, state_next;
  logic [PWM_BITS-1:0] pcnt_reg, pcnt_next;
  logic [DW-1:0]       div_reg, div_next;
  logic                wave_reg, wave_next;
  logic                last_reg, last_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic [AW-1:0]       active_reg, active_next;

  ch_state_t           ch_reg [CH];
  ch_state_t           ch_next [CH];
  ch_state_t           tick_ch [CH];
  logic [PWM_BITS-1:0] duty_reg [CH];
  logic [PWM_BITS-1:0] duty_next [CH];
  logic [PWM_BITS-1:0] tick_duty [CH];
  logic [HW-1:0]       hold_reg [CH];
  logic [HW-1:0]       hold_next [CH];
  logic [HW-1:0]       tick_hold [CH];

  logic period_end, step_tick, start_act, stop_take, launch, all_off;

  assign period_end = busy_reg && (pcnt_reg == DMAX);
  assign step_tick  = period_end && (div_reg == DIV_LAST);

  // Per-channel envelope advance on a step tick; saturating at both ends.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      tick_ch[i]   = ch_reg[i];
      tick_duty[i] = duty_reg[i];
      tick_hold[i] = hold_reg[i];
      if (step_tick) begin
        case (ch_reg[i])
          C_UP: begin
            if (duty_reg[i] >= DMAX - 1'b1) begin
              tick_duty[i] = DMAX;
              tick_ch[i]   = C_HOLD;
              tick_hold[i] = '0;
            end else begin
              tick_duty[i] = duty_reg[i] + 1'b1;
            end
          end
          C_HOLD: begin
            if (hold_reg[i] >= HOLD_LAST) tick_ch[i] = C_DOWN;
            else tick_hold[i] = hold_reg[i] + 1'b1;
          end
          C_DOWN: begin
            if (duty_reg[i] <= PWM_BITS'(1)) begin
              tick_duty[i] = '0;
              tick_ch[i]   = C_OFF;
            end else begin
              tick_duty[i] = duty_reg[i] - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Launch, abort, restart and global sequencing.
  always_comb begin
    start_act = ((state_reg == IDLE) && start && !stop) ||
                ((state_reg == RUN) && done_reg && loop && !stop);
    stop_take = (state_reg == RUN) && stop && !done_reg;

    launch = 1'b0;
    if ((state_reg == RUN) && step_tick && !last_reg && !stop_take && !done_reg &&
        (ch_reg[active_reg] == C_UP)) begin
      if (!wave_reg && (tick_ch[active_reg] == C_HOLD)) launch = 1'b1;
      if (wave_reg && (tick_duty[active_reg] == HALF)) launch = 1'b1;
    end

    all_off = 1'b1;
    for (int i = 0; i < CH; i++) begin
      ch_next[i]   = tick_ch[i];
      duty_next[i] = tick_duty[i];
      hold_next[i] = tick_hold[i];
      if (launch && (i == int'(active_reg) - 1)) begin
        ch_next[i]   = C_UP;
        duty_next[i] = '0;
        hold_next[i] = '0;
      end
      if (stop_take && ((tick_ch[i] == C_UP) || (tick_ch[i] == C_HOLD))) ch_next[i] = C_DOWN;
      if (start_act) begin
        ch_next[i]   = (i == CH - 1) ? C_UP : C_OFF;
        duty_next[i] = '0;
        hold_next[i] = '0;
      end
      if (ch_next[i] != C_OFF) all_off = 1'b0;
    end

    active_next = active_reg;
    last_next   = last_reg;
    wave_next   = wave_reg;
    if (launch) begin
      active_next = active_reg - 1'b1;
      last_next   = (active_reg == AW'(1));
    end
    if (start_act) begin
      active_next = TOP_CH;
      last_next   = (CH == 1);
      wave_next   = wave;
    end

    done_next = !done_reg && !start_act && all_off &&
                (((state_reg == RUN) && last_reg) || (state_reg == DRAIN));

    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_act) state_next = RUN;
      RUN: begin
        if (done_reg) state_next = start_act ? RUN : IDLE;
        else if (stop_take) state_next = DRAIN;
      end
      DRAIN:   if (done_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);

    pcnt_next = start_act ? '0 : (busy_reg ? pcnt_reg + 1'b1 : pcnt_reg);
    div_next  = div_reg;
    if (start_act) div_next = '0;
    else if (period_end) div_next = step_tick ? '0 : div_reg + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      pcnt_reg   <= '0;
      div_reg    <= '0;
      wave_reg   <= 1'b0;
      last_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      active_reg <= TOP_CH;
      for (int i = 0; i < CH; i++) begin
        ch_reg[i]   <= C_OFF;
        duty_reg[i] <= '0;
        hold_reg[i] <= '0;
      end
    end else begin
      state_reg  <= state_next;
      pcnt_reg   <= pcnt_next;
      div_reg    <= div_next;
      wave_reg   <= wave_next;
      last_reg   <= last_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      active_reg <= active_next;
      for (int i = 0; i < CH; i++) begin
        ch_reg[i]   <= ch_next[i];
        duty_reg[i] <= duty_next[i];
        hold_reg[i] <= hold_next[i];
      end
    end
  end

  assign busy       = busy_reg;
  assign cycle_done = done_reg;
  assign active_ch  = active_reg;

`ifdef LED_FADE_GAMMA_EN
  // Counter is delayed one clock so it stays aligned with the squared compare value.
  logic [PWM_BITS-1:0] pcnt_d_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt_d_reg <= '0;
    else pcnt_d_reg <= pcnt_reg;
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_pwm
    logic [2*PWM_BITS-1:0] prod;
    logic [PWM_BITS-1:0]   sq_reg;
    logic                  pwm_bit_reg;
    assign prod = {{PWM_BITS{1'b0}}, duty_reg[gi]} * {{PWM_BITS{1'b0}}, duty_reg[gi]};
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sq_reg      <= '0;
        pwm_bit_reg <= 1'b0;
      end else begin
        sq_reg      <= PWM_BITS'(prod >> PWM_BITS);
        pwm_bit_reg <= (pcnt_d_reg < sq_reg);
      end
    end
    assign pwm_out[gi] = pwm_bit_reg;
  end
`else
  for (genvar gi = 0; gi < CH; gi++) begin : g_pwm
    logic pwm_bit_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) pwm_bit_reg <= 1'b0;
      else pwm_bit_reg <= (pcnt_reg < duty_reg[gi]);
    end
    assign pwm_out[gi] = pwm_bit_reg;
  end
`endif

endmodule

// File: tb/tb_led_fade_scheduler.sv
// Directed bench for led_fade_scheduler with CH=8, PWM_BITS=3, STEP_DIV=1, HOLD_STEPS=2.
// Records one sample per clock after a start and compares per-period high-times to hand-derived envelopes.
module tb_led_fade_scheduler;
`ifdef LED_FADE_GAMMA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NREC = 700;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0, wave = 1'b0;
  logic [7:0] pwm_out;
  logic       busy, cycle_done;
  logic [2:0] active_ch;

  int checks = 0, failures = 0;
  logic [7:0] rec_pwm  [NREC];
  logic       rec_done [NREC];
  logic       rec_busy [NREC];
  logic [2:0] rec_act  [NREC];

  led_fade_scheduler #(.CH(8), .PWM_BITS(3), .STEP_DIV(1), .HOLD_STEPS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop), .wave(wave),
    .pwm_out(pwm_out), .busy(busy), .cycle_done(cycle_done), .active_ch(active_ch)
  );

  always #5 clk = ~clk;

  // Envelope of one channel, q step ticks after its launch: ramp 0..7, two extra holds, fall to 0.
  function automatic int prof(int q);
    if (q < 0 || q > 16) return 0;
    if (q <= 7) return q;
    if (q <= 9) return 7;
    return 16 - q;
  endfunction

  function automatic int expc(int d);
`ifdef LED_FADE_GAMMA_EN
    return (d * d) >> 3;
`else
    return d;
`endif
  endfunction

  function automatic int win(int ch, int s);
    int c;
    c = 0;
    for (int k = s; k < s + 8; k++) if (k < NREC) c += int'(rec_pwm[k][ch]);
    return c;
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Sample index k is the k-th clock after the start-accept edge.
  task automatic capture(int n, int start_at, int stop_at);
    for (int k = 0; k < n; k++) begin
      rec_pwm[k]  = pwm_out;
      rec_done[k] = cycle_done;
      rec_busy[k] = busy;
      rec_act[k]  = active_ch;
      start = (k == start_at);
      stop  = (k == stop_at);
      @(negedge clk);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset();
    int nd, nb;
    repeat (3) @(negedge clk);
    checks++;
    if (pwm_out !== 8'h00 || busy !== 1'b0 || cycle_done !== 1'b0 || active_ch !== 3'd7) begin
      failures++;
      $display("FAIL reset_init: pwm=%h busy=%b done=%b act=%0d required pwm=00 busy=0 done=0 act=7",
               pwm_out, busy, cycle_done, active_ch);
    end
    rst = 1'b0;
    pulse_start();
    repeat (60) @(negedge clk);
    checks++;
    if (pwm_out === 8'h00 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_prerun: pwm=%h busy=%b required nonzero pwm and busy=1", pwm_out, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pwm_out !== 8'h00 || busy !== 1'b0 || cycle_done !== 1'b0 || active_ch !== 3'd7) begin
      failures++;
      $display("FAIL reset_async: pwm=%h busy=%b done=%b act=%0d required pwm=00 busy=0 done=0 act=7",
               pwm_out, busy, cycle_done, active_ch);
    end
    @(negedge clk) rst = 1'b0;
    capture(100, -1, -1);
    nd = 0;
    nb = 0;
    for (int k = 0; k < 100; k++) begin
      if (rec_done[k]) nd++;
      if (rec_busy[k] || rec_pwm[k] != 8'h00) nb++;
    end
    checks++;
    if (nd != 0 || nb != 0) begin
      failures++;
      $display("FAIL reset_release: done_pulses=%0d active_samples=%0d required 0 and 0", nd, nb);
    end
    $display("tb: reset test complete");
  endtask

  task automatic test_chase();
    int nd, di, bad;
    wave = 1'b0;
    loop = 1'b0;
    pulse_start();
    capture(560, 100, -1);
    for (int ch = 0; ch < 8; ch++) begin
      bad = -1;
      for (int p = 0; p < 69 && bad < 0; p++)
        if (win(ch, 8 * p + LAT) != expc(prof(p - 7 * (7 - ch)))) bad = p;
      checks++;
      if (bad >= 0) begin
        failures++;
        $display("FAIL chase_profile ch%0d period %0d: high=%0d required=%0d",
                 ch, bad, win(ch, 8 * bad + LAT), expc(prof(bad - 7 * (7 - ch))));
      end
    end
    nd = 0;
    di = -1;
    for (int k = 0; k < 560; k++) if (rec_done[k]) begin nd++; if (di < 0) di = k; end
    checks++;
    if (nd != 1 || di != 520) begin
      failures++;
      $display("FAIL chase_done: pulses=%0d at=%0d required 1 at 520", nd, di);
    end
    checks++;
    if (rec_busy[0] !== 1'b1 || rec_busy[520] !== 1'b1 || rec_busy[521] !== 1'b0) begin
      failures++;
      $display("FAIL chase_busy: b0=%b b520=%b b521=%b required 1 1 0", rec_busy[0], rec_busy[520], rec_busy[521]);
    end
    bad = -1;
    for (int j = 1; j < 8; j++)
      if (rec_act[56 * j] != 3'(7 - j) || rec_act[56 * j - 1] != 3'(8 - j)) bad = j;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL chase_active: launch %0d act_before=%0d act_after=%0d required %0d %0d",
               bad, rec_act[56 * bad - 1], rec_act[56 * bad], 8 - bad, 7 - bad);
    end
    $display("tb: chase cycle captured, cycle_done at sample %0d", di);
  endtask

  task automatic test_wave();
    int nd, di, bad;
    wave = 1'b1;
    pulse_start();
    wave = 1'b0;
    capture(380, -1, -1);
    for (int ch = 0; ch < 8; ch++) begin
      bad = -1;
      for (int p = 0; p < 47 && bad < 0; p++)
        if (win(ch, 8 * p + LAT) != expc(prof(p - 4 * (7 - ch)))) bad = p;
      checks++;
      if (bad >= 0) begin
        failures++;
        $display("FAIL wave_profile ch%0d period %0d: high=%0d required=%0d",
                 ch, bad, win(ch, 8 * bad + LAT), expc(prof(bad - 4 * (7 - ch))));
      end
    end
    nd = 0;
    di = -1;
    for (int k = 0; k < 380; k++) if (rec_done[k]) begin nd++; if (di < 0) di = k; end
    checks++;
    if (nd != 1 || di != 352 || rec_busy[353] !== 1'b0) begin
      failures++;
      $display("FAIL wave_done: pulses=%0d at=%0d busy_after=%b required 1 at 352 busy 0", nd, di, rec_busy[353]);
    end
    bad = -1;
    for (int j = 1; j < 8; j++)
      if (rec_act[32 * j] != 3'(7 - j) || rec_act[32 * j - 1] != 3'(8 - j)) bad = j;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL wave_active: launch %0d act_before=%0d act_after=%0d required %0d %0d",
               bad, rec_act[32 * bad - 1], rec_act[32 * bad], 8 - bad, 7 - bad);
    end
    $display("tb: wave cycle captured, cycle_done at sample %0d", di);
  endtask

  task automatic test_stop();
    int nd, di, bad, e;
    wave = 1'b0;
    pulse_start();
    capture(120, -1, 41);
    bad = -1;
    for (int ch = 0; ch < 8; ch++)
      for (int p = 0; p < 14; p++) begin
        e = (ch != 7) ? 0 : (p <= 5) ? p : (p <= 10) ? 10 - p : 0;
        if (bad < 0 && win(ch, 8 * p + LAT) != expc(e)) bad = ch * 100 + p;
      end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL stop_profile ch%0d period %0d: high=%0d", bad / 100, bad % 100, win(bad / 100, 8 * (bad % 100) + LAT));
    end
    nd = 0;
    di = -1;
    for (int k = 0; k < 120; k++) if (rec_done[k]) begin nd++; if (di < 0) di = k; end
    checks++;
    if (nd != 1 || di != 80 || rec_busy[80] !== 1'b1 || rec_busy[81] !== 1'b0) begin
      failures++;
      $display("FAIL stop_done: pulses=%0d at=%0d b80=%b b81=%b required 1 at 80 1 0",
               nd, di, rec_busy[80], rec_busy[81]);
    end
    $display("tb: stop mid-ramp drained, cycle_done at sample %0d", di);
  endtask

  task automatic test_collision();
    int nb;
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    capture(30, -1, -1);
    nb = 0;
    for (int k = 0; k < 30; k++) if (rec_busy[k] || rec_done[k] || rec_pwm[k] != 8'h00) nb++;
    checks++;
    if (nb != 0) begin
      failures++;
      $display("FAIL start_stop_idle: active_samples=%0d required 0", nb);
    end
    $display("tb: start+stop in idle ignored");
  endtask

  task automatic test_loop();
    int nd, di, bad, waited;
    wave = 1'b0;
    loop = 1'b1;
    pulse_start();
    capture(600, -1, -1);
    nd = 0;
    di = -1;
    for (int k = 0; k < 600; k++) if (rec_done[k]) begin nd++; if (di < 0) di = k; end
    checks++;
    if (nd != 1 || di != 520 || rec_busy[521] !== 1'b1) begin
      failures++;
      $display("FAIL loop_done: pulses=%0d at=%0d busy521=%b required 1 at 520 busy 1", nd, di, rec_busy[521]);
    end
    checks++;
    if (rec_act[520] !== 3'd0 || rec_act[521] !== 3'd7) begin
      failures++;
      $display("FAIL loop_relaunch: act520=%0d act521=%0d required 0 7", rec_act[520], rec_act[521]);
    end
    bad = -1;
    for (int p = 0; p < 9 && bad < 0; p++)
      if (win(7, 521 + 8 * p + LAT) != expc(prof(p))) bad = p;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL loop_ramp period %0d: high=%0d required=%0d", bad, win(7, 521 + 8 * bad + LAT), expc(prof(bad)));
    end
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    waited = 0;
    while (busy === 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL loop_stop_drain: busy=%b after %0d cycles required 0", busy, waited);
    end
    loop = 1'b0;
    $display("tb: loop restart observed, stop drained in %0d cycles", waited);
  endtask

  initial begin
    test_reset();
    test_chase();
    test_wave();
    test_stop();
    test_collision();
    test_loop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_fade_scheduler.md
Name: led_fade_scheduler

Overview:
- Sequences a bank of CH LED PWM channels through staggered fade-in / hold / fade-out envelopes from one shared PWM counter and one step prescaler.
- Replaces per-channel free-running PWM controllers in the LED animation top; drives led_out directly in fade modes.
- Two launch policies: chase (next channel starts at peak) and wave (next channel starts at half brightness).

Parameters:
- CH, 8, number of LED channels; launch order is CH-1 down to 0.
- PWM_BITS, 6, duty/counter width; PWM period = 2^PWM_BITS clk.
- STEP_DIV, 2, PWM periods per duty step (>=1).
- HOLD_STEPS, 4, step ticks a channel stays at peak (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse; begins a cycle when IDLE.
- stop  in  1  single-cycle pulse; graceful abort.
- loop  in  1  1 = restart automatically after cycle completes.
- wave  in  1  launch policy: 0 = chase, 1 = wave; sampled at start accept.
- pwm_out  out  CH  per-channel PWM.
- busy  out  1  high in RUN or DRAIN.
- cycle_done  out  1  one-cycle pulse when all channels return to OFF.
- active_ch  out  clog2(CH)  index of last launched channel.

Behaviour:
- Reset values: pwm_out=0, busy=0, cycle_done=0, active_ch=CH-1. All counters and duties are 0, all channels OFF, global state IDLE.
- Global FSM states are IDLE, RUN and DRAIN.
- IDLE -> RUN:
  - Taken on start when stop is low.
  - That edge clears pcnt and div_cnt, latches wave, launches channel CH-1 (OFF->UP, duty 0), sets active_ch=CH-1 and sets busy.
- PWM counter pcnt (PWM_BITS):
  - Increments every clk while busy and wraps max->0.
  - period_end = (pcnt==2^PWM_BITS-1).
- Step prescaler:
  - div_cnt counts period_end events 0..STEP_DIV-1.
  - step_tick = period_end && div_cnt==STEP_DIV-1.
  - div_cnt wraps to 0 on step_tick.
- Channel FSM, updated only on step_tick:
  - OFF: idle.
  - UP: duty+1. When duty reaches max (2^PWM_BITS-1), go to HOLD and clear hold_cnt.
  - HOLD: hold_cnt+1. After HOLD_STEPS ticks, go to DOWN.
  - DOWN: duty-1. When duty reaches 0, go to OFF.
- Launch rule, in RUN only:
  - Evaluated on the step_tick edge, using post-update values of channel active_ch.
  - Chase: launch active_ch-1 when channel active_ch enters HOLD.
  - Wave: launch active_ch-1 when channel active_ch duty becomes 2^(PWM_BITS-1).
  - No launch after channel 0 has been launched.
- Completion:
  - When channel 0 has been launched and all channels are OFF: pulse cycle_done.
  - If loop=1 and the FSM is in RUN, perform the start action the next cycle.
  - Otherwise go to IDLE and clear busy.
- stop in RUN:
  - Go to DRAIN.
  - Every channel in UP or HOLD switches to DOWN with duty preserved.
  - No further launches.
  - DRAIN -> IDLE when all channels are OFF, with the cycle_done pulse.
  - loop is ignored in DRAIN.
- stop and start in the same cycle: stop wins; start is ignored.
- start while busy: ignored.
- PWM output:
  - pwm_out[i] = (pcnt < cmp[i]), registered, so 1 clk latency from pcnt.
  - cmp[i] = duty[i] when GAMMA is off.
  - duty 0 gives constant 0; max duty is high 2^PWM_BITS-1 of 2^PWM_BITS clk.
- All duty arithmetic saturates; no wrap past 0 or max.
- Asynchronous rst mid-operation clears everything immediately; pwm_out drops to 0 in the same reset assertion.

Optional Feature:
- Macro LED_FADE_GAMMA_EN.
- Defined: cmp[i] = (duty[i]*duty[i]) >> PWM_BITS, using a 2*PWM_BITS-bit product and one extra pipeline register. pwm_out latency from pcnt becomes 2 clk, and the pcnt compare is delayed to match.
- Undefined: cmp[i] = duty[i], linear, 1 clk latency.

Test Plan:
- Reset check. Assert rst mid-RUN, CH=8, PWM_BITS=3, STEP_DIV=1, HOLD_STEPS=2 -> pwm_out=0, busy=0, active_ch=7 while rst is high. No cycle_done after release.
- Chase launch timing. Same params, start, wave=0:
  - Channel 7 duty reaches 7 after 7 step_ticks (56 clk).
  - Channel 6 enters UP on that same tick.
  - Channel 7 high-time per period runs 1,2,...,7, holds 7 for 2 periods, then falls 6..0.
  - cycle_done after channel 0 returns to OFF; busy drops next cycle.
- Wave launch timing. wave=1 -> channel 6 launches on the tick where channel 7 duty=4 (4th step_tick). active_ch decrements every 4 step_ticks.
- Stop mid-ramp. stop when channel 7 duty=5 in UP and channel 6 is OFF:
  - Channel 7 falls 4,3,2,1,0 over 5 ticks; channel 6 never launches.
  - cycle_done pulses once, then IDLE.
- Loop and collisions:
  - loop=1 -> new cycle starts 1 clk after cycle_done, with channel 7 relaunched.
  - start+stop together in IDLE -> stays IDLE.
  - start during RUN -> no effect.
- Gamma build. LED_FADE_GAMMA_EN defined, PWM_BITS=3, duty=4 -> cmp=2; duty=7 -> cmp=6; pwm_out lags pcnt by 2 clk.
